// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Operands come straight from the register-file read ports; the result,
// latched destination index and a write enable go back to the write port
// through the writeback mux. One quotient bit is produced per cycle, and the
// pipeline stalls while busy is high.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst_n     synchronous active-low reset
//   start     request, accepted only in IDLE and only when kill is low
//   op        00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   rs1_data  dividend
//   rs2_data  divisor
//   rd_in     destination register index
//   kill      abort the in-flight operation (pipeline flush)
//   busy      high in CALC and DONE
//   done      one-cycle pulse, result valid
//   result    quotient or remainder, held until the next completion
//   rd_out    destination index of the last completed operation
//   wb_en     done with a non-zero destination, drives RegWrite
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd_in,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             wb_en
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic             is_rem_reg, is_rem_next;
  logic [4:0]       rd_reg, rd_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [WIDTH-1:0] quo_reg, quo_next;      // dividend shifts out, quotient shifts in
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [4:0]       rd_out_reg, rd_out_next;

  // Operand conditioning for a new request.
  logic             is_signed, s1, s2, div_zero, overflow;
  logic [WIDTH-1:0] abs1, abs2, special_res;

  assign is_signed = ~op[0];
  assign s1        = is_signed & rs1_data[WIDTH-1];
  assign s2        = is_signed & rs2_data[WIDTH-1];
  assign abs1      = s1 ? -rs1_data : rs1_data;
  assign abs2      = s2 ? -rs2_data : rs2_data;
  assign div_zero  = (rs2_data == '0);
  assign overflow  = is_signed && (rs1_data == MIN_NEG) && (rs2_data == '1);
  assign special_res = div_zero ? (op[1] ? rs1_data : '1)
                                : (op[1] ? '0 : MIN_NEG);

  // One restoring step. The trial subtraction is one bit wider than the
  // remainder so its MSB is a clean borrow flag.
  logic [WIDTH+1:0] wide, diff;
  logic             q_bit;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step, q_fix, r_fix;
  logic             last_iter;

  assign wide      = {rem_reg, quo_reg[WIDTH-1]};
  assign diff      = wide - {2'b00, divisor_reg};
  assign q_bit     = ~diff[WIDTH+1];
  assign rem_step  = q_bit ? diff[WIDTH:0] : wide[WIDTH:0];
  assign quo_step  = {quo_reg[WIDTH-2:0], q_bit};
  assign q_fix     = neg_q_reg ? -quo_step : quo_step;
  assign r_fix     = neg_r_reg ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
  assign last_iter = (count_reg == CW'(WIDTH-1));

  always_comb begin
    state_next   = state_reg;
    is_rem_next  = is_rem_reg;
    rd_next      = rd_reg;
    divisor_next = divisor_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    count_next   = count_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    result_next  = result_reg;
    rd_out_next  = rd_out_reg;

    case (state_reg)
      IDLE: begin
        if (start && !kill) begin
          is_rem_next = op[1];
          rd_next     = rd_in;
          if (div_zero || overflow) begin
            // Architecturally defined results, no iteration needed.
            result_next = special_res;
            rd_out_next = rd_in;
            state_next  = DONE;
          end else begin
            quo_next     = abs1;
            divisor_next = abs2;
            rem_next     = '0;
            count_next   = '0;
            neg_q_next   = s1 ^ s2;
            neg_r_next   = s1;
            state_next   = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_next = IDLE;
        end else begin
          rem_next   = rem_step;
          quo_next   = quo_step;
          count_next = count_reg + CW'(1);
          if (last_iter) begin
            // Sign fix-up folded into the final step so result is ready in DONE.
            result_next = is_rem_reg ? r_fix : q_fix;
            rd_out_next = rd_reg;
            state_next  = DONE;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      is_rem_reg  <= 1'b0;
      rd_reg      <= '0;
      divisor_reg <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      count_reg   <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_reg  <= '0;
      rd_out_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      is_rem_reg  <= is_rem_next;
      rd_reg      <= rd_next;
      divisor_reg <= divisor_next;
      quo_reg     <= quo_next;
      rem_reg     <= rem_next;
      count_reg   <= count_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      result_reg  <= result_next;
      rd_out_reg  <= rd_out_next;
    end
  end

  // A flush during the DONE cycle suppresses the pulse immediately.
  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE) && !kill;
  assign result = result_reg;
  assign rd_out = rd_out_reg;
  assign wb_en  = done && (rd_out_reg != 5'd0);

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits directly downstream of the register file: it consumes the two read-port operands (rs1/rs2 data) and the destination index.
- It produces a result and a one-cycle write-enable that feed the register file's write port (WriteData/rd/RegWrite) through the writeback mux.
- Radix-2 restoring algorithm, one quotient bit per cycle; the core pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/result width (only 32 is verified)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request; accepted only when busy=0
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
rs1_data  input  WIDTH  dividend
rs2_data  input  WIDTH  divisor
rd_in  input  5  destination register index
kill  input  1  abort in-flight operation (pipeline flush)
busy  output  1  high in CALC and DONE states
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  quotient or remainder per op
rd_out  output  5  latched rd_in
wb_en  output  1  done && rd_out != 0; drives register-file RegWrite

Behaviour:
- Reset (rst_n=0 sampled at an edge): state=IDLE; busy=0, done=0, wb_en=0, result=0, rd_out=0; internal counter/remainder/quotient cleared. Reset overrides all other inputs, including mid-operation; no done is issued for the aborted op.
- States are IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge k: latch op, rd_in, operands.
  - Signed ops: latch |rs1|, |rs2| plus sign flags (quotient sign = s1^s2; remainder sign = s1).
  - Go to CALC with count=0, or directly to DONE for special cases.
- CALC:
  - Each edge shifts the partial remainder left by one, brings in the next dividend MSB, and subtracts the divisor if no borrow (quotient bit=1).
  - count increments; after the 32nd iteration edge (k+32), go to DONE.
- DONE:
  - done=1 for exactly one cycle; result and rd_out are stable during it.
  - Next edge: go to IDLE, done=0. result and rd_out hold their last value until the next completion.
- Latency:
  - Normal op: done is visible in the cycle after edge k+32 (32 cycles after the start edge).
  - Special cases: done is visible in the cycle after edge k.
- Sign fix-up is applied when entering DONE:
  - Quotient negated if the quotient sign is set.
  - Remainder negated if the remainder sign is set.
  - Signed division truncates toward zero.
- Special cases (RISC-V defined, no trap):
  - Divisor 0: DIV/DIVU result = all ones (0xFFFFFFFF); REM/REMU result = rs1_data unchanged.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, op DIV/REM): DIV = 0x80000000, REM = 0.
- start while busy=1 (CALC or DONE): ignored, with no effect on in-flight state. Callers hold start until busy=0.
- kill=1 at any edge while in CALC or DONE: next state IDLE, done/wb_en forced 0 that cycle and after, result is not updated.
- kill in IDLE together with start: kill wins, request is not accepted.
- rd_in=0: the operation runs normally and done pulses, but wb_en stays 0.
- Arithmetic: internal remainder register is WIDTH+1 bits for the borrow; all outputs are truncated to WIDTH. No X on outputs after reset.

Test Plan:
- DIV, rs1=0xFFFFFFF9 (-7), rs2=2 -> done 32 cycles after start, result=0xFFFFFFFD (-3). Same operands with REM -> 0xFFFFFFFF (-1).
- DIVU 100/7 -> 14. REMU 100/7 -> 2. wb_en=1 with rd_out=5 when rd_in=5; busy high for exactly 33 cycles.
- Divide by zero, rs1=5, rs2=0: DIV -> 0xFFFFFFFF, DIVU -> 0xFFFFFFFF, REMU -> 5. done appears the cycle after the start edge.
- Overflow, rs1=0x80000000, rs2=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0, one-cycle latency. The same operands with DIVU -> 0 (normal 32-cycle path).
- Start DIVU 1000/3, assert a second start at cycle 10 (ignored), then kill at cycle 20 -> no done, busy=0 next cycle. A new start then completes with 333.
- Assert rst_n=0 at cycle 15 of an op -> next cycle busy=0, done=0, result=0. rd_in=0 run -> done=1, wb_en=0.
